store_load_sequencer: RTL
=========================

Name: store_load_sequencer

Overview:
- Multicycle FSM that sequences every memory load and store in the datapath.
- Issues the memory read, latches the memory data register and drives the store-size merge selector; stores then get the memory write, loads the register write-back with the load-size selector.
- Handles the byte and half-word read-modify-write: old word read into the memory data register, merged with the B operand, written back.
- Sits between the main control unit (start/op) and the memory, memory data register, store-size merge and load-size extract blocks.

Parameters:
- MEM_LATENCY, 2: cycles mem_rd is held before memory read data is valid at the memory data register input; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request from main control; sampled only in IDLE.
- op  input  3  000 LW, 001 LH, 010 LB, 100 SW, 101 SH, 110 SB; 011 and 111 are illegal.
- addr_low  input  2  ALU result bits [1:0], sampled with start.
- mem_rd  output  1  memory read enable.
- mem_wr  output  1  memory write enable.
- mdr_load  output  1  memory data register load enable.
- set_store_size_control  output  2  00 byte, 01 half, 10 word; never 11.
- load_size_control  output  2  00 byte, 01 half, 10 word; never 11.
- reg_write  output  1  register file write enable for load write-back.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  one-cycle fault pulse, coincident with done.

Behaviour:
- States: IDLE, READ, LATCH, WRITE, WB, DONE, FAULT.
- All outputs are Moore: decoded from registered state and a registered size field. No combinational path from any input to any output.
- Reset (asynchronous, any state, mid-operation included):
  - state goes to IDLE, latency counter to 0.
  - mem_rd, mem_wr, mdr_load, reg_write, busy, done and misaligned all 0.
  - Both size controls 2'b10.
- IDLE, start=1: register op and the size (byte/half/word) derived from op. Alignment check:
  - word op needs addr_low==00; half op needs addr_low[0]==0; byte ops are always aligned.
  - misaligned -> FAULT.
  - illegal op -> DONE, with no memory access and no fault.
  - SW -> WRITE (no read needed).
  - all others -> READ.
- IDLE, start=0: stay in IDLE.
- READ:
  - mem_rd=1 for exactly MEM_LATENCY consecutive cycles; a 3-bit down-counter is loaded with MEM_LATENCY-1 on entry.
  - Exit when the counter is 0 -> LATCH.
- LATCH:
  - mdr_load=1 for one cycle.
  - Store ops -> WRITE; load ops -> WB.
- WRITE:
  - mem_wr=1 for one cycle, with set_store_size_control = registered size -> DONE.
- WB:
  - reg_write=1 for one cycle, with load_size_control = registered size -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- FAULT: done=1 and misaligned=1 for one cycle -> IDLE. No memory or register write ever occurs for a faulting op.
- Size controls:
  - Both equal the registered size from the cycle after start until the cycle after DONE/FAULT.
  - In IDLE both are 2'b10.
  - mem_wr and mem_rd are never high in the same cycle.
- start while busy is ignored and not queued. start is accepted in the same cycle the FSM is in IDLE, including the cycle right after DONE.
- Latency, with start accepted at cycle t and L = MEM_LATENCY:
  - SW: WRITE at t+1, done at t+2.
  - SH/SB: READ t+1..t+L, LATCH t+L+1, WRITE t+L+2, done t+L+3.
  - Loads: same as SH/SB with WB in place of WRITE.
  - Fault or illegal op: done at t+1.

Decomposition:
- Shared package store_load_pkg holds:
  - op encodings (OP_LW .. OP_SB);
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, reused by set_store_size and the load-size block;
  - state enum.
- One natural sub-module: store_load_latency_counter, the loadable down-counter with zero flag.
- Alignment check and op-to-size decode stay inline as combinational logic.

Test Plan:
- Reset mid-READ (L=2, SB in flight) -> next cycle all enables 0, busy=0, both size controls 10; a new start is then accepted normally.
- SW, addr_low=00, start at t -> mem_wr=1 and set_store_size_control=10 at t+1, done at t+2, mem_rd never asserted.
- SB, addr_low=11, L=2, start at t -> mem_rd at t+1..t+2, mdr_load at t+3, mem_wr with set_store_size_control=00 at t+4, done at t+5.
- LH, addr_low=10, L=1 -> mem_rd at t+1, mdr_load at t+2, reg_write with load_size_control=01 at t+3, done at t+4.
- LW with addr_low=01, then SH with addr_low=11 -> each gives done=1 and misaligned=1 at t+1; mem_rd, mem_wr and reg_write stay 0.
- start pulses during an SH in flight, and op=111 from IDLE -> the in-flight op completes with unchanged timing; op=111 gives done at t+1 with misaligned=0 and no enables asserted.

Source files
------------

// File: rtl/store_load_pkg.sv
// Shared encodings for the load/store sequencer: op codes, access sizes and FSM states.
package store_load_pkg;

   localparam logic [2:0] OP_LW = 3'b000;
   localparam logic [2:0] OP_LH = 3'b001;
   localparam logic [2:0] OP_LB = 3'b010;
   localparam logic [2:0] OP_SW = 3'b100;
   localparam logic [2:0] OP_SH = 3'b101;
   localparam logic [2:0] OP_SB = 3'b110;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_LATCH,
      ST_WRITE,
      ST_WB,
      ST_DONE,
      ST_FAULT
   } state_t;

   // Illegal ops (x11) map to word so the size controls never show 2'b11.
   function automatic logic [1:0] op_to_size(input logic [2:0] op);
      case (op[1:0])
         2'b01:   return SIZE_HALF;
         2'b10:   return SIZE_BYTE;
         default: return SIZE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/store_load_latency_counter.sv
// Loadable 3-bit down-counter that times the memory read phase; saturates at zero.
module store_load_latency_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic [2:0] i_load_val,
   input  logic       i_dec,
   output logic       o_zero
);

   logic [2:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= 3'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != 3'd0)) begin
         r_count <= r_count - 3'd1;
      end
   end

   assign o_zero = (r_count == 3'd0);

endmodule

// File: rtl/store_load_sequencer.sv
// Multicycle load/store sequencer: memory read, MDR latch, store merge write or load write-back.
//
// state    | meaning
// ST_IDLE  | waiting for start; size controls parked at word
// ST_READ  | mem_rd held for MEM_LATENCY cycles
// ST_LATCH | mdr_load, old word / load data captured
// ST_WRITE | mem_wr with store-size merge selector
// ST_WB    | reg_write with load-size selector
// ST_DONE  | done pulse
// ST_FAULT | done + misaligned pulse, nothing written
module store_load_sequencer
   import store_load_pkg::*;
#(
   parameter int MEM_LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [1:0] addr_low,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       mdr_load,
   output logic [1:0] set_store_size_control,
   output logic [1:0] load_size_control,
   output logic       reg_write,
   output logic       busy,
   output logic       done,
   output logic       misaligned
);

   state_t     r_state;
   logic [2:0] r_op;
   logic [1:0] r_size;
   logic       r_mem_rd;
   logic       r_mem_wr;
   logic       r_mdr_load;
   logic       r_reg_write;
   logic       r_busy;
   logic       r_done;
   logic       r_misaligned;
   logic [1:0] r_size_ctl;

   state_t     w_next_state;
   logic [2:0] w_next_op;
   logic [1:0] w_next_size;
   logic [1:0] w_op_size;
   logic       w_illegal;
   logic       w_misaligned;
   logic       w_cnt_load;
   logic       w_cnt_zero;

   store_load_latency_counter u_latency_counter (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_cnt_load),
      .i_load_val (3'(MEM_LATENCY - 1)),
      .i_dec      (r_state == ST_READ),
      .o_zero     (w_cnt_zero)
   );

   always_comb begin
      w_next_state = r_state;
      w_next_op    = r_op;
      w_next_size  = r_size;
      w_cnt_load   = 1'b0;
      w_op_size    = op_to_size(op);
      w_illegal    = (op[1:0] == 2'b11);
      w_misaligned = ((w_op_size == SIZE_WORD) && (addr_low != 2'b00)) ||
                     ((w_op_size == SIZE_HALF) && addr_low[0]);
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_op   = op;
               w_next_size = w_op_size;
               if (w_illegal) begin
                  w_next_state = ST_DONE;
               end else if (w_misaligned) begin
                  w_next_state = ST_FAULT;
               end else if (op == OP_SW) begin
                  w_next_state = ST_WRITE;
               end else begin
                  w_next_state = ST_READ;
                  w_cnt_load   = 1'b1;
               end
            end
         end
         ST_READ:  if (w_cnt_zero) w_next_state = ST_LATCH;
         ST_LATCH: w_next_state = r_op[2] ? ST_WRITE : ST_WB;
         ST_WRITE: w_next_state = ST_DONE;
         ST_WB:    w_next_state = ST_DONE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one lines up with r_state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_op         <= OP_LW;
         r_size       <= SIZE_WORD;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mdr_load   <= 1'b0;
         r_reg_write  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_misaligned <= 1'b0;
         r_size_ctl   <= SIZE_WORD;
      end else begin
         r_state      <= w_next_state;
         r_op         <= w_next_op;
         r_size       <= w_next_size;
         r_mem_rd     <= (w_next_state == ST_READ);
         r_mem_wr     <= (w_next_state == ST_WRITE);
         r_mdr_load   <= (w_next_state == ST_LATCH);
         r_reg_write  <= (w_next_state == ST_WB);
         r_busy       <= (w_next_state != ST_IDLE);
         r_done       <= (w_next_state == ST_DONE) || (w_next_state == ST_FAULT);
         r_misaligned <= (w_next_state == ST_FAULT);
         r_size_ctl   <= (w_next_state == ST_IDLE) ? SIZE_WORD : w_next_size;
      end
   end

   assign mem_rd                 = r_mem_rd;
   assign mem_wr                 = r_mem_wr;
   assign mdr_load               = r_mdr_load;
   assign reg_write              = r_reg_write;
   assign busy                   = r_busy;
   assign done                   = r_done;
   assign misaligned             = r_misaligned;
   assign set_store_size_control = r_size_ctl;
   assign load_size_control      = r_size_ctl;

endmodule
